// File: rtl/holy_axi_line_master.sv
// holy_axi_line_master
// Moves one whole cache line per request between a HOLY cache line buffer and
// an AXI4 bus, using one INCR burst for a refill (AR/R) or a writeback (AW/W/B).
//
// Ports
//   aclk, aresetn            clock, asynchronous active-low reset
//   req_valid/req_ready      line request handshake (req_ready only in IDLE)
//   req_write, req_addr      1 = writeback, 0 = refill; line address (offset bits dropped)
//   fill_valid/idx/data      refill word strobe, word index, word data
//   wb_idx, wb_data          writeback word index out, word returned by the cache
//   done, err, busy          completion pulse, error flag valid with done, FSM active
//   m_axi_*                  AXI4 master channels AW, W, B, AR, R
//
// Compile-time option HOLY_AXI_WRITE_EN: when defined, the AW/W/B path and
// writebacks are built. When undefined the master is read-only; a write request
// is accepted and answered with done+err and no bus activity.
module holy_axi_line_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 16,
  parameter int ID_WIDTH   = 4,
  parameter int AXI_ID     = 0,
  localparam int IDX_WIDTH = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  output logic                    fill_valid,
  output logic [IDX_WIDTH-1:0]    fill_idx,
  output logic [DATA_WIDTH-1:0]   fill_data,
  output logic [IDX_WIDTH-1:0]    wb_idx,
  input  logic [DATA_WIDTH-1:0]   wb_data,
  output logic                    done,
  output logic                    err,
  output logic                    busy,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int OFF_BITS = $clog2(LINE_WORDS * DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
    ~((ADDR_WIDTH'(1) << OFF_BITS) - ADDR_WIDTH'(1));
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(LINE_WORDS - 1);
  localparam logic [7:0]           AX_LEN   = 8'(LINE_WORDS - 1);
  localparam logic [2:0]           AX_SIZE  = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [ID_WIDTH-1:0]  ID       = ID_WIDTH'(AXI_ID);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
`ifdef HOLY_AXI_WRITE_EN
    S_AW,
    S_W,
    S_B,
`endif
    S_DONE
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [IDX_WIDTH-1:0]    cnt_reg, cnt_next;
  logic                    err_reg, err_next;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg <= S_IDLE;
      addr_reg  <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    cnt_next      = cnt_reg;
    err_next      = err_reg;
    req_ready     = 1'b0;
    fill_valid    = 1'b0;
    fill_data     = '0;
    done          = 1'b0;
    m_axi_arid    = '0;
    m_axi_araddr  = '0;
    m_axi_arlen   = '0;
    m_axi_arsize  = '0;
    m_axi_arburst = '0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    m_axi_awid    = '0;
    m_axi_awaddr  = '0;
    m_axi_awlen   = '0;
    m_axi_awsize  = '0;
    m_axi_awburst = '0;
    m_axi_awvalid = 1'b0;
    m_axi_wdata   = '0;
    m_axi_wstrb   = '0;
    m_axi_wlast   = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;

    case (state_reg)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_next = req_addr & ADDR_MASK;
          cnt_next  = '0;
          err_next  = 1'b0;
`ifdef HOLY_AXI_WRITE_EN
          state_next = req_write ? S_AW : S_AR;
`else
          // Read-only build: a writeback cannot be served, so report it at once.
          if (req_write) begin
            state_next = S_DONE;
            err_next   = 1'b1;
          end else begin
            state_next = S_AR;
          end
`endif
        end
      end

      S_AR: begin
        m_axi_arvalid = 1'b1;
        m_axi_arid    = ID;
        m_axi_araddr  = addr_reg;
        m_axi_arlen   = AX_LEN;
        m_axi_arsize  = AX_SIZE;
        m_axi_arburst = 2'b01;
        if (m_axi_arready) state_next = S_R;
      end

      S_R: begin
        m_axi_rready = 1'b1;
        fill_valid   = m_axi_rvalid;
        fill_data    = m_axi_rdata;
        if (m_axi_rvalid) begin
          if (m_axi_rresp != 2'b00 || m_axi_rid != ID) err_next = 1'b1;
          if (cnt_reg == LAST_IDX) begin
            // Final counted beat; the slave must mark it with rlast.
            state_next = S_DONE;
            cnt_next   = '0;
            if (!m_axi_rlast) err_next = 1'b1;
          end else if (m_axi_rlast) begin
            // Burst cut short by the slave: stop accepting beats.
            state_next = S_DONE;
            cnt_next   = '0;
            err_next   = 1'b1;
          end else begin
            cnt_next = cnt_reg + IDX_WIDTH'(1);
          end
        end
      end

`ifdef HOLY_AXI_WRITE_EN
      S_AW: begin
        m_axi_awvalid = 1'b1;
        m_axi_awid    = ID;
        m_axi_awaddr  = addr_reg;
        m_axi_awlen   = AX_LEN;
        m_axi_awsize  = AX_SIZE;
        m_axi_awburst = 2'b01;
        if (m_axi_awready) state_next = S_W;
      end

      S_W: begin
        m_axi_wvalid = 1'b1;
        m_axi_wdata  = wb_data;
        m_axi_wstrb  = '1;
        m_axi_wlast  = (cnt_reg == LAST_IDX);
        if (m_axi_wready) begin
          if (cnt_reg == LAST_IDX) begin
            state_next = S_B;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + IDX_WIDTH'(1);
          end
        end
      end

      S_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00 || m_axi_bid != ID) err_next = 1'b1;
          state_next = S_DONE;
        end
      end
`endif

      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

  assign fill_idx = cnt_reg;
  assign err      = err_reg;
  assign busy     = (state_reg != S_IDLE);

`ifdef HOLY_AXI_WRITE_EN
  assign wb_idx = cnt_reg;
`else
  assign wb_idx = '0;
  // Write-side inputs have no consumer in the read-only build.
  logic unused_write_inputs;
  assign unused_write_inputs = ^{m_axi_awready, m_axi_wready, m_axi_bid,
                                 m_axi_bresp, m_axi_bvalid, wb_data};
`endif

endmodule

// File: tb/tb_holy_axi_line_master.sv
// Scoreboard bench for holy_axi_line_master: a 32-bit/16-word instance and a
// 64-bit/1-word instance. Stimulus tasks push expected fill beats and
// completions; negedge monitors pop and compare whenever the DUT presents them.
module tb_holy_axi_line_master;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  // ---------------- DUT0: 32-bit, 16 words ----------------
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic        fill_valid;
  logic [3:0]  fill_idx, wb_idx;
  logic [31:0] fill_data, wb_data;
  logic        done, err, busy;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [31:0] wb_mem [16];

  assign wb_data = wb_mem[wb_idx];

  holy_axi_line_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_WORDS(16),
                         .ID_WIDTH(4), .AXI_ID(0)) dut0 (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .fill_valid(fill_valid), .fill_idx(fill_idx), .fill_data(fill_data),
    .wb_idx(wb_idx), .wb_data(wb_data), .done(done), .err(err), .busy(busy),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready), .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready), .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready), .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  // ---------------- DUT1: 64-bit, 1 word ----------------
  logic        d1_req_valid, d1_req_ready, d1_req_write;
  logic [31:0] d1_req_addr;
  logic        d1_fill_valid;
  logic [0:0]  d1_fill_idx, d1_wb_idx;
  logic [63:0] d1_fill_data, d1_wb_data;
  logic        d1_done, d1_err, d1_busy;
  logic [3:0]  d1_awid, d1_arid, d1_bid, d1_rid;
  logic [31:0] d1_awaddr, d1_araddr;
  logic [63:0] d1_wdata, d1_rdata;
  logic [7:0]  d1_awlen, d1_arlen, d1_wstrb;
  logic [2:0]  d1_awsize, d1_arsize;
  logic [1:0]  d1_awburst, d1_arburst, d1_bresp, d1_rresp;
  logic        d1_awvalid, d1_awready, d1_wlast, d1_wvalid, d1_wready, d1_bvalid, d1_bready;
  logic        d1_arvalid, d1_arready, d1_rlast, d1_rvalid, d1_rready;

  holy_axi_line_master #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .LINE_WORDS(1),
                         .ID_WIDTH(4), .AXI_ID(0)) dut1 (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(d1_req_valid), .req_ready(d1_req_ready), .req_write(d1_req_write),
    .req_addr(d1_req_addr), .fill_valid(d1_fill_valid), .fill_idx(d1_fill_idx),
    .fill_data(d1_fill_data), .wb_idx(d1_wb_idx), .wb_data(d1_wb_data), .done(d1_done),
    .err(d1_err), .busy(d1_busy),
    .m_axi_awid(d1_awid), .m_axi_awaddr(d1_awaddr), .m_axi_awlen(d1_awlen),
    .m_axi_awsize(d1_awsize), .m_axi_awburst(d1_awburst), .m_axi_awvalid(d1_awvalid),
    .m_axi_awready(d1_awready), .m_axi_wdata(d1_wdata), .m_axi_wstrb(d1_wstrb),
    .m_axi_wlast(d1_wlast), .m_axi_wvalid(d1_wvalid), .m_axi_wready(d1_wready),
    .m_axi_bid(d1_bid), .m_axi_bresp(d1_bresp), .m_axi_bvalid(d1_bvalid),
    .m_axi_bready(d1_bready), .m_axi_arid(d1_arid), .m_axi_araddr(d1_araddr),
    .m_axi_arlen(d1_arlen), .m_axi_arsize(d1_arsize), .m_axi_arburst(d1_arburst),
    .m_axi_arvalid(d1_arvalid), .m_axi_arready(d1_arready), .m_axi_rid(d1_rid),
    .m_axi_rdata(d1_rdata), .m_axi_rresp(d1_rresp), .m_axi_rlast(d1_rlast),
    .m_axi_rvalid(d1_rvalid), .m_axi_rready(d1_rready)
  );

  // ---------------- scoreboard ----------------
  typedef struct { logic [63:0] data; logic [7:0] idx; } fill_t;
  typedef struct { logic err; int lat; } done_t;

  fill_t exp_fill[$];
  done_t exp_done[$];
  fill_t d1_exp_fill[$];
  done_t d1_exp_done[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int d1_acc_cyc = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge aclk) begin
    fill_t f;
    done_t d;
    if (aresetn) begin
      if (req_valid && req_ready) acc_cyc = cyc;
      if (fill_valid) begin
        if (exp_fill.size() == 0) chk("fill_unexpected", 64'(fill_idx), 64'hFFFF);
        else begin
          f = exp_fill.pop_front();
          chk("fill_idx", 64'(fill_idx), 64'(f.idx));
          chk("fill_data", 64'(fill_data), f.data);
        end
      end
      if (done) begin
        if (exp_done.size() == 0) chk("done_unexpected", 64'(done), 64'h0);
        else begin
          d = exp_done.pop_front();
          chk("done_err", 64'(err), 64'(d.err));
          if (d.lat >= 0) chk("done_latency", 64'(cyc - acc_cyc + 1), 64'(d.lat));
          $display("dut0 line done: err=%0b latency=%0d", err, cyc - acc_cyc + 1);
        end
      end
    end
  end

  always @(negedge aclk) begin
    fill_t f;
    done_t d;
    if (aresetn) begin
      if (d1_req_valid && d1_req_ready) d1_acc_cyc = cyc;
      if (d1_fill_valid) begin
        if (d1_exp_fill.size() == 0) chk("d1_fill_unexpected", 64'(d1_fill_idx), 64'hFFFF);
        else begin
          f = d1_exp_fill.pop_front();
          chk("d1_fill_idx", 64'(d1_fill_idx), 64'(f.idx));
          chk("d1_fill_data", d1_fill_data, f.data);
        end
      end
      if (d1_done) begin
        if (d1_exp_done.size() == 0) chk("d1_done_unexpected", 64'(d1_done), 64'h0);
        else begin
          d = d1_exp_done.pop_front();
          chk("d1_done_err", 64'(d1_err), 64'(d.err));
          chk("d1_done_latency", 64'(cyc - d1_acc_cyc + 1), 64'(d.lat));
          $display("dut1 line done: err=%0b latency=%0d", d1_err, cyc - d1_acc_cyc + 1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [31:0] beat_data(input logic [31:0] a, input int b);
    return a ^ 32'h5A5A_0000 ^ (32'(b) * 32'h0001_0111);
  endfunction

  task automatic drive_beat(input logic [31:0] addr, input int b, input int last_beat,
                            input int resp_beat, input int id_beat);
    rvalid = 1'b1;
    rdata  = beat_data(addr, b);
    rlast  = (b == last_beat);
    rresp  = (b == resp_beat) ? 2'b10 : 2'b00;
    rid    = (b == id_beat) ? 4'd3 : 4'd0;
  endtask

  // Refill with a zero-wait slave. last_beat: beat carrying rlast (-1 none);
  // resp_beat/id_beat: beat with SLVERR / wrong rid; abort_beat: reset during it.
  task automatic refill(input logic [31:0] addr, input logic [31:0] exp_addr,
                        input int nbeats, input int last_beat, input int resp_beat,
                        input int id_beat, input int abort_beat,
                        input logic exp_err, input int exp_lat);
    for (int b = 0; b < nbeats; b++) exp_fill.push_back('{64'(beat_data(addr, b)), 8'(b)});
    exp_done.push_back('{exp_err, exp_lat});
    arready   = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = addr;
    #1 chk("req_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 1'b0;
    chk("arvalid", 64'(arvalid), 64'h1);
    chk("araddr", 64'(araddr), 64'(exp_addr));
    chk("arlen", 64'(arlen), 64'd15);
    chk("arsize", 64'(arsize), 64'd2);
    chk("arburst", 64'(arburst), 64'd1);
    chk("arid", 64'(arid), 64'd0);
    chk("err_cleared", 64'(err), 64'h0);
    drive_beat(addr, 0, last_beat, resp_beat, id_beat);
    tick();
    for (int b = 0; b < nbeats; b++) begin
      if (b == abort_beat) begin
        #2 aresetn = 1'b0;
        #1;
        chk("rst_arvalid", 64'(arvalid), 64'h0);
        chk("rst_rready", 64'(rready), 64'h0);
        chk("rst_fill_valid", 64'(fill_valid), 64'h0);
        chk("rst_fill_idx", 64'(fill_idx), 64'h0);
        chk("rst_fill_data", 64'(fill_data), 64'h0);
        chk("rst_araddr", 64'(araddr), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        exp_fill.delete();
        exp_done.delete();
        rvalid = 1'b0;
        rlast  = 1'b0;
        $display("dut0 refill 0x%08h aborted by reset at beat %0d", addr, b);
        return;
      end
      tick();
      if (b + 1 < nbeats) drive_beat(addr, b + 1, last_beat, resp_beat, id_beat);
      else begin
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        rid    = 4'd0;
      end
    end
    chk("rready_after_burst", 64'(rready), 64'h0);
    tick();
    chk("busy_idle", 64'(busy), 64'h0);
  endtask

`ifdef HOLY_AXI_WRITE_EN
  task automatic writeback(input logic [31:0] addr, input logic [31:0] exp_addr,
                           input bit stall, input logic [1:0] resp,
                           input logic exp_err, input int exp_lat);
    int beat = 0;
    bit aw_hs = 0;
    bit b_hs  = 0;
    for (int i = 0; i < 16; i++) wb_mem[i] = addr ^ (32'(i) * 32'h1357_9BDF);
    exp_done.push_back('{exp_err, exp_lat});
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = addr;
    #1 chk("wr_req_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 1'b0;
    for (int cy = 0; cy < 300 && !b_hs; cy++) begin
      awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bvalid  = (beat == 16) ? (stall ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
      bresp   = resp;
      bid     = 4'd0;
      #1;
      if (awvalid) begin
        chk("awaddr", 64'(awaddr), 64'(exp_addr));
        chk("awlen", 64'(awlen), 64'd15);
        chk("awsize", 64'(awsize), 64'd2);
        chk("awburst", 64'(awburst), 64'd1);
      end
      if (!aw_hs) chk("w_before_aw", 64'(wvalid), 64'h0);
      if (wvalid) begin
        chk("wdata", 64'(wdata), 64'(wb_mem[beat]));
        chk("wb_idx", 64'(wb_idx), 64'(beat));
        chk("wstrb", 64'(wstrb), 64'hF);
        chk("wlast", 64'(wlast), 64'(beat == 15));
      end else begin
        chk("wlast_idle", 64'(wlast), 64'h0);
      end
      if (awvalid && awready) aw_hs = 1;
      if (wvalid && wready) beat++;
      if (bvalid && bready) b_hs = 1;
      tick();
    end
    bvalid = 1'b0;
    chk("b_handshake", 64'(b_hs), 64'h1);
    chk("beats_written", 64'(beat), 64'd16);
    chk("done_no_valids", 64'({awvalid, wvalid, bready}), 64'h0);
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    aresetn = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0; bid = '0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = '0; rid = '0; rdata = '0;
    for (int i = 0; i < 16; i++) wb_mem[i] = '0;
    d1_req_valid = 1'b0; d1_req_write = 1'b0; d1_req_addr = '0; d1_wb_data = '0;
    d1_awready = 1'b0; d1_wready = 1'b0; d1_bvalid = 1'b0; d1_bresp = '0; d1_bid = '0;
    d1_arready = 1'b0; d1_rvalid = 1'b0; d1_rlast = 1'b0; d1_rresp = '0; d1_rid = '0;
    d1_rdata = '0;

    repeat (3) tick();
    chk("reset_valids", 64'({arvalid, awvalid, wvalid, rready, bready, wlast}), 64'h0);
    chk("reset_done_err_busy", 64'({done, err, busy}), 64'h0);
    chk("reset_araddr", 64'(araddr), 64'h0);
    chk("reset_fill_idx", 64'(fill_idx), 64'h0);
    aresetn = 1'b1;
    tick();

    // Clean refill: aligned address, 16 beats, done on the 19th cycle.
    refill(32'h8000_0044, 32'h8000_0040, 16, 15, -1, -1, -1, 1'b0, 19);
    // rlast on beat 7 and SLVERR on beat 3: stops after beat 7 with err.
    refill(32'h1000_0010, 32'h1000_0000, 8, 7, 3, -1, -1, 1'b1, 11);
    // No rlast on the final beat.
    refill(32'h2000_00FC, 32'h2000_00C0, 16, -1, -1, -1, -1, 1'b1, 19);
    // Wrong rid on beat 10.
    refill(32'h3000_0000, 32'h3000_0000, 16, 15, -1, 10, -1, 1'b1, 19);
    // Reset during beat 5, then a new request right after release.
    refill(32'h4000_0080, 32'h4000_0080, 16, 15, -1, -1, 5, 1'b0, 19);
    repeat (2) tick();
    aresetn = 1'b1;
    refill(32'h5000_0047, 32'h5000_0040, 16, 15, -1, -1, -1, 1'b0, 19);

`ifdef HOLY_AXI_WRITE_EN
    writeback(32'h6000_0123, 32'h6000_0100, 1'b0, 2'b10, 1'b1, 20);
    writeback(32'h7000_03C4, 32'h7000_03C0, 1'b1, 2'b00, 1'b0, -1);
`else
    // Read-only build: a writeback is refused with done+err two cycles on.
    exp_done.push_back('{1'b1, 2});
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h6000_0123;
    #1 chk("ro_req_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 1'b0;
    chk("ro_no_bus", 64'({arvalid, awvalid, wvalid, bready}), 64'h0);
    tick();
    chk("ro_no_bus_after", 64'({arvalid, awvalid, wvalid, bready, busy}), 64'h0);
    tick();
`endif

    // DUT1 refill: 64-bit single-beat line.
    d1_exp_fill.push_back('{64'h0123_4567_89AB_CDEF, 8'd0});
    d1_exp_done.push_back('{1'b0, 4});
    d1_arready   = 1'b1;
    d1_req_valid = 1'b1;
    d1_req_write = 1'b0;
    d1_req_addr  = 32'h1234_567F;
    #1 chk("d1_req_ready", 64'(d1_req_ready), 64'h1);
    tick();
    d1_req_valid = 1'b0;
    chk("d1_arvalid", 64'(d1_arvalid), 64'h1);
    chk("d1_araddr", 64'(d1_araddr), 64'h1234_5678);
    chk("d1_arlen", 64'(d1_arlen), 64'd0);
    chk("d1_arsize", 64'(d1_arsize), 64'd3);
    d1_rvalid = 1'b1;
    d1_rdata  = 64'h0123_4567_89AB_CDEF;
    d1_rlast  = 1'b1;
    tick();
    tick();
    d1_rvalid = 1'b0;
    d1_rlast  = 1'b0;
    chk("d1_rready_done", 64'(d1_rready), 64'h0);
    tick();

`ifdef HOLY_AXI_WRITE_EN
    d1_exp_done.push_back('{1'b0, 5});
    d1_awready   = 1'b1;
    d1_wready    = 1'b1;
    d1_wb_data   = 64'hDEAD_BEEF_0BAD_F00D;
    d1_req_valid = 1'b1;
    d1_req_write = 1'b1;
    d1_req_addr  = 32'hAAAA_5555;
    #1 chk("d1_wr_req_ready", 64'(d1_req_ready), 64'h1);
    tick();
    d1_req_valid = 1'b0;
    chk("d1_awvalid", 64'(d1_awvalid), 64'h1);
    chk("d1_awaddr", 64'(d1_awaddr), 64'hAAAA_5550);
    chk("d1_awlen", 64'(d1_awlen), 64'd0);
    chk("d1_awsize", 64'(d1_awsize), 64'd3);
    chk("d1_w_before_aw", 64'(d1_wvalid), 64'h0);
    tick();
    chk("d1_wvalid", 64'(d1_wvalid), 64'h1);
    chk("d1_wlast", 64'(d1_wlast), 64'h1);
    chk("d1_wdata", d1_wdata, 64'hDEAD_BEEF_0BAD_F00D);
    chk("d1_wstrb", 64'(d1_wstrb), 64'hFF);
    chk("d1_wb_idx", 64'(d1_wb_idx), 64'h0);
    tick();
    chk("d1_bready", 64'(d1_bready), 64'h1);
    d1_bvalid = 1'b1;
    d1_bresp  = 2'b00;
    tick();
    d1_bvalid = 1'b0;
    tick();
`endif

    repeat (2) tick();
    chk("sb_fill_drained", 64'(exp_fill.size()), 64'h0);
    chk("sb_done_drained", 64'(exp_done.size()), 64'h0);
    chk("d1_sb_fill_drained", 64'(d1_exp_fill.size()), 64'h0);
    chk("d1_sb_done_drained", 64'(d1_exp_done.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
